mult_issue_ctrl: RTL and testbench

Issue controller that sits directly upstream of the sequential radix-4 Booth multiplier (32x32 -> 64, signed) and directly consumes its product. Accepts operand pairs on a valid/ready stream, buffers them in a small FIFO, and drives the multiplier's `start`/`a`/`b`/`start_shift`/`start_i` inputs. Counts the fixed multiplier latency, then captures `read_data3` into a held result register exposed on a valid/ready output stream.

---
 rtl/mult_issue_ctrl_pkg.sv | 7 +
 rtl/mult_issue_ctrl_op_fifo.sv | 45 ++++
 rtl/mult_issue_ctrl.sv | 121 ++++++++++++
 tb/tb_mult_issue_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_issue_ctrl_pkg.sv
// mult_issue_ctrl_pkg: shared FSM state type and fixed multiplier control constants
package mult_issue_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RUN, WAIT} state_t;
    localparam logic [4:0] MUL_START_SHIFT = 5'd0;
    localparam logic [4:0] MUL_START_I = 5'd1;
    localparam int MUL_LAT_DEFAULT = 10;
endpackage

// File: rtl/mult_issue_ctrl_op_fifo.sv
// op_fifo: synchronous FIFO with wrap-around pointers and a separate occupancy count
module op_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    assign w_push = push && !full;
    assign w_pop = pop && !empty;
    assign full = r_cnt == (AW+1)'(DEPTH);
    assign empty = r_cnt == '0;
    assign count = r_cnt;
    assign dout = r_mem[r_rd];
    // storage array, written at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end
    // pointers and count; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issues queued operand pairs to a sequential Booth multiplier and holds its product (optional MULT_ISSUE_STATS_EN)
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
#(
    parameter int N = 32,
    parameter int DEPTH = 2,
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           mul_start,
    output logic [N-1:0]   mul_a,
    output logic [N-1:0]   mul_b,
    output logic [4:0]     mul_start_shift,
    output logic [4:0]     mul_start_i,
    input  logic [2*N-1:0] mul_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p
`ifdef MULT_ISSUE_STATS_EN
    ,
    output logic [31:0]    stat_ops,
    output logic [31:0]    stat_stall
`endif
);
    localparam int CW = $clog2(MUL_LAT) + 1;
    localparam int FW = $clog2(DEPTH) + 1;
    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_mul_start;
    logic [N-1:0]   r_mul_a;
    logic [N-1:0]   r_mul_b;
    logic           r_out_valid;
    logic [2*N-1:0] r_out_p;
    logic           w_full;
    logic           w_empty;
    logic [FW-1:0]  w_count;
    logic [2*N-1:0] w_head;
    logic           w_push;
    logic           w_pop;
    logic           w_cap;
    assign w_push = in_valid && in_ready;
    assign w_pop = r_state == IDLE && !w_empty;
    assign w_cap = ((r_state == RUN && r_cnt == '0) || r_state == WAIT) && (!r_out_valid || out_ready);
    assign in_ready = !w_full;
    assign mul_start = r_mul_start;
    assign mul_a = r_mul_a;
    assign mul_b = r_mul_b;
    assign mul_start_shift = MUL_START_SHIFT;
    assign mul_start_i = MUL_START_I;
    assign out_valid = r_out_valid;
    assign out_p = r_out_p;
    op_fifo #(.W(2*N), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(w_push),
        .pop(w_pop),
        .din({in_b, in_a}),
        .dout(w_head),
        .full(w_full),
        .empty(w_empty),
        .count(w_count)
    );
    a_count_bound: assert property (@(posedge clk) disable iff (rst) w_count <= FW'(DEPTH));
    // issue FSM: pop, pulse start, count latency, capture into the held output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_mul_start <= 1'b0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_out_valid <= 1'b0;
            r_out_p <= '0;
        end else begin
            r_mul_start <= 1'b0;
            if (w_cap) begin
                r_out_p <= mul_p;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: if (!w_empty) begin
                    r_mul_a <= w_head[N-1:0];
                    r_mul_b <= w_head[2*N-1:N];
                    r_mul_start <= 1'b1;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    r_cnt <= CW'(MUL_LAT - 1);
                    r_state <= RUN;
                end
                RUN: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                     else r_state <= w_cap ? IDLE : WAIT;
                WAIT: if (w_cap) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
`ifdef MULT_ISSUE_STATS_EN
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_stall;
    assign stat_ops = r_stat_ops;
    assign stat_stall = r_stat_stall;
    // completed-capture and WAIT-cycle counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_ops <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_cap) r_stat_ops <= r_stat_ops + 1'b1;
            if (r_state == WAIT) r_stat_stall <= r_stat_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: randomized scoreboard bench with a behavioural multiplier model
module tb_mult_issue_ctrl;
    localparam int N = 32;
    localparam int DEPTH = 2;
    localparam int MUL_LAT = 10;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, mul_start, out_valid, out_ready;
    logic [N-1:0] in_a, in_b, mul_a, mul_b;
    logic [4:0] mul_start_shift, mul_start_i;
    logic [2*N-1:0] mul_p = '0;
    logic [2*N-1:0] out_p;
`ifdef MULT_ISSUE_STATS_EN
    logic [31:0] stat_ops, stat_stall;
`endif
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    int mk = 0;
    logic [63:0] mprod = '0;

    always #5 clk = ~clk;

    mult_issue_ctrl #(.N(N), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_start_shift(mul_start_shift), .mul_start_i(mul_start_i), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
`ifdef MULT_ISSUE_STATS_EN
        , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
    );

    function automatic logic [63:0] smul(logic [31:0] a, logic [31:0] b);
        logic signed [63:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // multiplier model: garbage until MUL_LAT edges after the start edge, then the product held
    always @(posedge clk) begin
        if (mul_start) begin
            mk <= MUL_LAT - 1;
            mprod <= smul(mul_a, mul_b);
            mul_p <= {$urandom, $urandom};
        end else if (mk > 1) begin
            mk <= mk - 1;
            mul_p <= {$urandom, $urandom};
        end else if (mk == 1) begin
            mk <= 0;
            mul_p <= mprod;
        end
    end

    // scoreboard: record accepted operands, compare every delivered product
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_p);
                end else chk("product", out_p, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(smul(in_a, in_b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [31:0] a, logic [31:0] b);
        logic acc;
        acc = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_out(string name, logic [63:0] exp);
        for (int t = 0; t < 100 && !out_valid; t++) step();
        chk(name, out_p, exp);
    endtask

    task automatic drain(string name);
        for (int t = 0; t < 2000 && (exp_q.size() != 0 || out_valid); t++) step();
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_reset(string name);
        chk({name, "_in_ready"}, in_ready, 1);
        chk({name, "_mul_start"}, mul_start, 0);
        chk({name, "_mul_a"}, mul_a, 0);
        chk({name, "_mul_b"}, mul_b, 0);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_out_p"}, out_p, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        step();
        step();
        chk_reset("reset");
        chk("start_shift", mul_start_shift, 0);
        chk("start_i", mul_start_i, 1);
        rst = 1'b0;
        // single op latency
        out_ready = 1'b1;
        in_a = 3;
        in_b = 5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("start_early", mul_start, 0);
        step();
        chk("start_pulse", mul_start, 1);
        repeat (MUL_LAT) step();
        chk("valid_early", out_valid, 0);
        step();
        chk("valid_rise", out_valid, 1);
        chk("single_3x5", out_p, 15);
        drain("drain_single");
        // signed corners
        push(32'hFFFF_FFF9, 6);
        wait_out("signed_m7x6", 64'hFFFF_FFFF_FFFF_FFD6);
        push(32'h8000_0000, 32'h8000_0000);
        wait_out("signed_min_sq", 64'h4000_0000_0000_0000);
        drain("drain_signed");
        // fifo full: one in flight plus two held
        push(7, 8);
        push(9, 10);
        push(11, 12);
        chk("fifo_full", in_ready, 0);
        drain("drain_full");
        // back-pressure
        out_ready = 1'b0;
        push(11, 13);
        push(32'hFFFF_FFFE, 3);
        push(100, 200);
        repeat (20) step();
        chk("bp_valid", out_valid, 1);
        chk("bp_hold", out_p, 143);
`ifdef MULT_ISSUE_STATS_EN
        chk("bp_stall", stat_stall != 0, 1);
`endif
        out_ready = 1'b1;
        drain("drain_bp");
        // reset mid-RUN with an entry still queued
        push(9, 9);
        push(4, 4);
        for (int t = 0; t < 20 && !mul_start; t++) step();
        chk("mid_start", mul_start, 1);
        repeat (6) step();
        rst = 1'b1;
        step();
        chk_reset("midrst");
        rst = 1'b0;
        repeat (30) step();
        chk("flushed", out_valid, 0);
        push(2, 2);
        wait_out("after_reset_2x2", 4);
        drain("drain_reset");
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom % 2) == 0;
            in_a = rnd32();
            in_b = rnd32();
            out_ready = ($urandom % 4) != 0;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("drain_random");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
